// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian crossing controller.
// Optional conflict checking is enabled with PED_CONFLICT_CHECK_EN.
package ped_pkg;

    typedef enum logic [1:0] {
        DONT_WALK = 2'd0,
        WALK      = 2'd1,
        FLASH     = 2'd2
    } ped_state_e;

    localparam int DEF_CNT_WIDTH    = 16;
    localparam int DEF_WALK_CYCLES  = 30;
    localparam int DEF_FLASH_CYCLES = 16;
    localparam int DEF_BLINK_HALF   = 2;

    // A healthy signal head lights exactly one of its three lamps.
    function automatic logic lamps_one_hot(input logic r, input logic y, input logic g);
        return ({r, y, g} == 3'b100) || ({r, y, g} == 3'b010) || ({r, y, g} == 3'b001);
    endfunction

endpackage

// File: rtl/ped_axis_fsm.sv
// One crosswalk: request latch, green edge detect, DONT_WALK/WALK/FLASH FSM,
// phase and blink counters. All outputs come straight from flops.
module ped_axis_fsm
    import ped_pkg::*;
#(
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int WALK_CYCLES  = DEF_WALK_CYCLES,
    parameter int FLASH_CYCLES = DEF_FLASH_CYCLES,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic red,
    input  logic yellow,
    input  logic green,
    input  logic btn,
    input  logic block,
    output logic walk,
    output logic dont_walk,
    output logic req
);

    localparam logic [1:0] S_DONT_WALK = DONT_WALK;
    localparam logic [1:0] S_WALK      = WALK;
    localparam logic [1:0] S_FLASH     = FLASH;

    localparam logic [CNT_WIDTH-1:0] WALK_LAST  = CNT_WIDTH'(WALK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] FLASH_LAST = CNT_WIDTH'(FLASH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] BLINK_LAST = CNT_WIDTH'(BLINK_HALF - 1);

    logic [1:0]           state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] blink_cnt, blink_cnt_nxt;
    logic                 blink_on, blink_on_nxt;
    logic                 green_q, green_rise;
    logic                 req_nxt;
    logic                 state_change;

    // Next-state, counter, blink and request-latch logic.
    always_comb begin
        green_rise    = green & ~green_q;
        state_nxt     = state;
        cnt_nxt       = '0;
        blink_cnt_nxt = '0;
        blink_on_nxt  = 1'b1;
        req_nxt       = req;

        case (state)
            S_DONT_WALK: if (green_rise && (req || btn)) state_nxt = S_WALK;
            // Red wins over yellow when both are lit.
            S_WALK: begin
                if (red)                            state_nxt = S_DONT_WALK;
                else if (yellow || cnt == WALK_LAST) state_nxt = S_FLASH;
            end
            // Yellow deliberately does not shorten the flash.
            S_FLASH: if (red || cnt == FLASH_LAST) state_nxt = S_DONT_WALK;
            default: state_nxt = S_DONT_WALK;
        endcase

        if (block) state_nxt = S_DONT_WALK;

        state_change = (state_nxt != state);

        // Phase counter restarts on every entry; idle in DONT_WALK so it never wraps.
        if (!state_change && state_nxt != S_DONT_WALK) cnt_nxt = cnt + 1'b1;

        // Blink phase restarts lit on FLASH entry, then toggles every BLINK_HALF cycles.
        if (state_nxt == S_FLASH && !state_change) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt = '0;
                blink_on_nxt  = ~blink_on;
            end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
                blink_on_nxt  = blink_on;
            end
        end

        // Presses outside WALK latch; entering WALK consumes the request.
        if (state != S_WALK && btn) req_nxt = 1'b1;
        if (state != S_WALK && state_nxt == S_WALK) req_nxt = 1'b0;
    end

    // State, counters and registered lamp outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_DONT_WALK;
            cnt       <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            green_q   <= 1'b0;
            req       <= 1'b0;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_on  <= blink_on_nxt;
            green_q   <= green;
            req       <= req_nxt;
            walk      <= (state_nxt == S_WALK);
            dont_walk <= (state_nxt == S_DONT_WALK) || (state_nxt == S_FLASH && blink_on_nxt);
        end
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: two independent crosswalk FSMs driven by
// the intersection lamp states. Define PED_CONFLICT_CHECK_EN to add the sticky
// lamp/walk conflict detector that forces both crosswalks to DONT_WALK.
module ped_crossing_ctrl
    import ped_pkg::*;
#(
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int WALK_CYCLES  = DEF_WALK_CYCLES,
    parameter int FLASH_CYCLES = DEF_FLASH_CYCLES,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic ns_red,
    input  logic ns_yellow,
    input  logic ns_green,
    input  logic ew_red,
    input  logic ew_yellow,
    input  logic ew_green,
    input  logic ns_btn,
    input  logic ew_btn,
    output logic ns_walk,
    output logic ew_walk,
    output logic ns_dont_walk,
    output logic ew_dont_walk,
    output logic ns_req,
    output logic ew_req,
    output logic fault
);

    logic block;

`ifdef PED_CONFLICT_CHECK_EN
    logic conflict;
    logic fault_q;

    // Any crossed greens, broken signal head, or two WALKs at once is a conflict.
    always_comb begin
        conflict = (ns_green & ew_green)
                 | ~lamps_one_hot(ns_red, ns_yellow, ns_green)
                 | ~lamps_one_hot(ew_red, ew_yellow, ew_green)
                 | (ns_walk & ew_walk);
    end

    // Sticky fault; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_q | conflict;
    end

    // Blocking on the live conflict too drops the walks on the same edge fault rises.
    assign block = fault_q | conflict;
    assign fault = fault_q;
`else
    assign block = 1'b0;
    assign fault = 1'b0;
`endif

    ped_axis_fsm #(
        .CNT_WIDTH(CNT_WIDTH), .WALK_CYCLES(WALK_CYCLES),
        .FLASH_CYCLES(FLASH_CYCLES), .BLINK_HALF(BLINK_HALF)
    ) u_ns (
        .clk(clk), .rst(rst),
        .red(ns_red), .yellow(ns_yellow), .green(ns_green),
        .btn(ns_btn), .block(block),
        .walk(ns_walk), .dont_walk(ns_dont_walk), .req(ns_req)
    );

    ped_axis_fsm #(
        .CNT_WIDTH(CNT_WIDTH), .WALK_CYCLES(WALK_CYCLES),
        .FLASH_CYCLES(FLASH_CYCLES), .BLINK_HALF(BLINK_HALF)
    ) u_ew (
        .clk(clk), .rst(rst),
        .red(ew_red), .yellow(ew_yellow), .green(ew_green),
        .btn(ew_btn), .block(block),
        .walk(ew_walk), .dont_walk(ew_dont_walk), .req(ew_req)
    );

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl: directed vector table, hand
// sequences for multi-cycle corners, and randomized intersection traffic
// against a behavioural model.
module tb_ped_crossing_ctrl;

    localparam int WC = 4;
    localparam int FC = 4;
    localparam int BH = 1;
    localparam int L_R = 0, L_Y = 1, L_G = 2;

    logic clk = 1'b0;
    logic rst;
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic ns_btn, ew_btn;
    logic ns_walk, ew_walk, ns_dont_walk, ew_dont_walk, ns_req, ew_req, fault;

    int checks   = 0;
    int failures = 0;

    ped_crossing_ctrl #(
        .CNT_WIDTH(16), .WALK_CYCLES(WC), .FLASH_CYCLES(FC), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst(rst),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .ns_btn(ns_btn), .ew_btn(ew_btn),
        .ns_walk(ns_walk), .ew_walk(ew_walk),
        .ns_dont_walk(ns_dont_walk), .ew_dont_walk(ew_dont_walk),
        .ns_req(ns_req), .ew_req(ew_req), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   lamp;
        logic btn;
        logic w;
        logic dw;
        logic rq;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lamps(input int ns, input int ew);
        ns_red = (ns == L_R); ns_yellow = (ns == L_Y); ns_green = (ns == L_G);
        ew_red = (ew == L_R); ew_yellow = (ew == L_Y); ew_green = (ew == L_G);
    endtask

    task automatic add(input int lamp, input logic btn, input logic w, input logic dw, input logic rq);
        vec_t v;
        v.lamp = lamp; v.btn = btn; v.w = w; v.dw = dw; v.rq = rq;
        vt.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 = DONT_WALK, 1 = WALK, 2 = FLASH; age = cycles already spent in mode.
    int m_mode[2];
    int m_age[2];
    bit m_req[2];
    bit m_pg[2];
    bit m_fault;

    function automatic bit m_walk(input int a);
        return m_mode[a] == 1;
    endfunction

    function automatic bit m_dw(input int a);
        return (m_mode[a] == 0) || (m_mode[a] == 2 && ((m_age[a] / BH) % 2 == 0));
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_mode[a] = 0; m_age[a] = 0; m_req[a] = 0; m_pg[a] = 0;
        end
        m_fault = 0;
    endtask

    task automatic model_axis(input int a, input bit r, input bit y, input bit g, input bit b, input bit blk);
        bit rise;
        int nm;
        rise = g && !m_pg[a];
        m_pg[a] = g;
        nm = m_mode[a];
        if (m_mode[a] == 0) begin
            if (rise && (m_req[a] || b)) nm = 1;
        end else if (m_mode[a] == 1) begin
            if (r) nm = 0;
            else if (y || m_age[a] + 1 >= WC) nm = 2;
        end else begin
            if (r || m_age[a] + 1 >= FC) nm = 0;
        end
        if (blk) nm = 0;
        if (m_mode[a] != 1 && nm == 1) m_req[a] = 0;
        else if (m_mode[a] != 1 && b) m_req[a] = 1;
        m_age[a] = (nm == m_mode[a]) ? m_age[a] + 1 : 0;
        m_mode[a] = nm;
    endtask

    task automatic model_step();
        bit blk;
        blk = 0;
`ifdef PED_CONFLICT_CHECK_EN
        begin
            bit c;
            c = (ns_green && ew_green)
              || ((int'(ns_red) + int'(ns_yellow) + int'(ns_green)) != 1)
              || ((int'(ew_red) + int'(ew_yellow) + int'(ew_green)) != 1)
              || (m_walk(0) && m_walk(1));
            blk = m_fault || c;
            m_fault = m_fault || c;
        end
`endif
        model_axis(0, ns_red, ns_yellow, ns_green, ns_btn, blk);
        model_axis(1, ew_red, ew_yellow, ew_green, ew_btn, blk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int phase, left, nsl, ewl;
        logic [6:0] got, exp;

        rst = 1'b1; ns_btn = 1'b0; ew_btn = 1'b0;
        set_lamps(L_R, L_R);
        tick(); tick();
        chk("reset_state", {ns_walk, ns_dont_walk, ns_req, ew_walk, ew_dont_walk, ew_req, fault}, 7'b0100100);
        rst = 1'b0;

        // NS request then green: 4 WALK, blink 1010, steady; then same-cycle press;
        // then a mid-green press that waits for the next green; short green + yellow.
        add(L_R,0, 0,1,0); add(L_R,1, 0,1,1); add(L_R,0, 0,1,1);
        add(L_G,0, 1,0,0); add(L_G,0, 1,0,0); add(L_G,0, 1,0,0); add(L_G,0, 1,0,0);
        add(L_G,0, 0,1,0); add(L_G,0, 0,0,0); add(L_G,0, 0,1,0); add(L_G,0, 0,0,0);
        add(L_G,0, 0,1,0); add(L_G,0, 0,1,0); add(L_Y,0, 0,1,0); add(L_R,0, 0,1,0);
        add(L_R,0, 0,1,0); add(L_G,1, 1,0,0); add(L_G,1, 1,0,0);
        add(L_Y,0, 0,1,0); add(L_Y,0, 0,0,0); add(L_R,0, 0,1,0);
        add(L_G,0, 0,1,0); add(L_G,0, 0,1,0); add(L_G,1, 0,1,1); add(L_Y,0, 0,1,1);
        add(L_R,0, 0,1,1); add(L_G,0, 1,0,0); add(L_G,0, 1,0,0);
        add(L_Y,0, 0,1,0); add(L_Y,0, 0,0,0); add(L_Y,0, 0,1,0); add(L_Y,0, 0,0,0);
        add(L_R,0, 0,1,0);

        foreach (vt[i]) begin
            set_lamps(vt[i].lamp, L_R);
            ns_btn = vt[i].btn;
            tick();
            chk($sformatf("vec%0d_ns", i), {ns_walk, ns_dont_walk, ns_req}, {vt[i].w, vt[i].dw, vt[i].rq});
            chk($sformatf("vec%0d_ew", i), {ew_walk, ew_dont_walk, ew_req}, 3'b010);
        end
        ns_btn = 1'b0;

        // EW: press during WALK ignored, press during FLASH latched and served next green.
        set_lamps(L_R, L_R); ew_btn = 1'b1; tick(); ew_btn = 1'b0;
        chk("ew_req_set", ew_req, 1'b1);
        set_lamps(L_R, L_G); tick();
        chk("ew_walk_grant", {ew_walk, ew_req}, 2'b10);
        ew_btn = 1'b1; tick(); ew_btn = 1'b0;
        chk("ew_press_in_walk", {ew_walk, ew_req}, 2'b10);
        set_lamps(L_R, L_Y); tick();
        chk("ew_flash_entry", {ew_walk, ew_dont_walk}, 2'b01);
        ew_btn = 1'b1; tick(); ew_btn = 1'b0;
        chk("ew_press_in_flash", {ew_walk, ew_dont_walk, ew_req}, 3'b001);
        set_lamps(L_R, L_R); tick();
        chk("ew_red_exit", {ew_walk, ew_dont_walk, ew_req}, 3'b011);
        set_lamps(L_R, L_G); tick();
        chk("ew_walk_regrant", {ew_walk, ew_dont_walk, ew_req}, 3'b100);
        set_lamps(L_R, L_R); tick();

        // Async reset in the middle of an NS WALK.
        ns_btn = 1'b1; tick(); ns_btn = 1'b0;
        set_lamps(L_G, L_R); tick(); tick();
        chk("ns_walk_before_rst", ns_walk, 1'b1);
        ns_btn = 1'b1; tick();
        chk("ns_req_in_walk", ns_req, 1'b0);
        ns_btn = 1'b0;
        set_lamps(L_R, L_R); ew_btn = 1'b1; tick(); ew_btn = 1'b0;
        #2 rst = 1'b1;
        #1 chk("async_rst_outputs", {ns_walk, ns_dont_walk, ns_req, ew_req}, 4'b0100);
        tick(); #3 rst = 1'b0;

        // Randomized intersection cycle against the model.
        model_reset();
        phase = 5; left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (left == 0) begin
                phase = (phase + 1) % 6;
                // Sometimes skip yellow to exercise red-in-WALK.
                if ((phase == 1 || phase == 4) && $urandom_range(3) == 0) phase = phase + 1;
                left = (phase == 0 || phase == 3) ? $urandom_range(8, 1) :
                       (phase == 2 || phase == 5) ? $urandom_range(3, 1) : $urandom_range(5, 1);
            end
            left--;
            nsl = (phase == 0) ? L_G : (phase == 1) ? L_Y : L_R;
            ewl = (phase == 3) ? L_G : (phase == 4) ? L_Y : L_R;
            set_lamps(nsl, ewl);
            ns_btn = ($urandom_range(4) == 0);
            ew_btn = ($urandom_range(4) == 0);
            model_step();
            tick();
            got = {ns_walk, ns_dont_walk, ns_req, ew_walk, ew_dont_walk, ew_req, fault};
            exp = {m_walk(0), m_dw(0), m_req[0], m_walk(1), m_dw(1), m_req[1], m_fault};
            if (got !== exp && failures > 20) begin
                failures++; checks++;
            end else begin
                chk($sformatf("rand_cyc%0d", c), got, exp);
            end
        end
        ns_btn = 1'b0; ew_btn = 1'b0;

`ifdef PED_CONFLICT_CHECK_EN
        // Crossed greens while NS is walking: fault sticks, both walks drop.
        set_lamps(L_R, L_R); ns_btn = 1'b1; tick(); ns_btn = 1'b0; tick();
        set_lamps(L_G, L_R); tick();
        chk("pre_fault_walk", {ns_walk, fault}, 2'b10);
        ns_green = 1'b1; ew_green = 1'b1; ew_red = 1'b0;
        tick();
        chk("fault_set", {fault, ns_walk, ew_walk, ns_dont_walk}, 4'b1001);
        set_lamps(L_R, L_R); ew_btn = 1'b1; tick(); ew_btn = 1'b0;
        set_lamps(L_R, L_G); tick(); tick();
        chk("fault_sticky_blocks", {fault, ns_walk, ew_walk, ew_dont_walk}, 4'b1001);
`else
        chk("fault_tied_low", fault, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing controller sitting directly downstream of the intersection traffic-light FSM. It consumes the six lamp outputs (NS/EW red, yellow, green) and two debounced pedestrian push-button requests. It drives WALK / DONT_WALK lamps for the two crosswalks. The NS crosswalk runs parallel to NS traffic, and the EW crosswalk runs parallel to EW traffic. A walk phase is granted only at the start of a green phase with a pending request, and it is always cut short if that axis leaves green.

## Interface
- CNT_WIDTH, 16: width of the phase and blink counters.
- WALK_CYCLES, 30: steady WALK duration in clock cycles; must be ≥1.
- FLASH_CYCLES, 16: flashing DONT_WALK duration; must be ≥1.
- BLINK_HALF, 2: half-period of the flash blink in cycles; must be ≥1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- ns_red, ns_yellow, ns_green  in  1 each  NS lamp state from the light controller.
- ew_red, ew_yellow, ew_green  in  1 each  EW lamp state from the light controller.
- ns_btn, ew_btn  in  1 each  debounced, synchronous, level-high pedestrian requests.
- ns_walk, ew_walk  out  1 each  WALK lamp.
- ns_dont_walk, ew_dont_walk  out  1 each  DONT_WALK lamp; blinks during FLASH.
- ns_req, ew_req  out  1 each  request pending ("WAIT" indicator).
- fault  out  1  sticky conflict flag (see Configuration).

## Operation
- Each axis is handled by an identical, independent FSM with states DONT_WALK, WALK and FLASH.
- Request latch:
  - Set when btn=1 in any state other than WALK.
  - Cleared on the transition into WALK.
  - Presses during WALK are ignored.
- green_rise is defined as green=1 while the registered previous green=0.
- DONT_WALK → WALK: on green_rise when (req | btn). A press on the same cycle as the green edge counts.
- WALK:
  - After WALK_CYCLES cycles, go to FLASH.
  - If yellow=1, go to FLASH early.
  - If red=1, go to DONT_WALK immediately.
- FLASH:
  - After FLASH_CYCLES cycles, go to DONT_WALK.
  - If red=1, go to DONT_WALK immediately.
  - Yellow does not shorten FLASH.
- Outputs by state:
  - DONT_WALK: walk=0, dont_walk=1.
  - WALK: walk=1, dont_walk=0.
  - FLASH: walk=0; dont_walk=1 for BLINK_HALF cycles, then 0 for BLINK_HALF cycles, repeating. The blink phase restarts at 1 on every FLASH entry.
- Counters:
  - Reset to 0 on every state entry and increment each cycle in state.
  - Exit condition is count == DURATION-1.
  - Counters never wrap in a legal configuration.
- Safety invariant: walk=1 implies the same-axis green=1 on the same cycle, except for the one registered cycle after green drops. That cycle is closed by the forced exit.

## Timing
- All outputs are registered, with 1 cycle of latency from the sampled input.
- Reset values: walk=0, dont_walk=1, req=0, fault=0, previous green=0, all counters 0, FSM=DONT_WALK.
- Reset mid-operation: outputs return to their reset values asynchronously, and pending requests are lost.
- WALK asserts on the edge that samples green_rise and lasts exactly WALK_CYCLES cycles unless truncated.
- Request display: req goes high on the edge after btn is sampled and drops on the edge where walk rises.
- Simultaneous red and yellow inputs: red takes priority.

## Configuration
- Macro: PED_CONFLICT_CHECK_EN.
- Defined:
  - fault sets when ns_green&ew_green, when any axis has ≠1 lamp lit, or when ns_walk&ew_walk.
  - fault is sticky until rst.
  - While fault=1, both FSMs are forced to DONT_WALK and new WALK entries are blocked.
- Undefined: fault is tied to 0 and no checking logic is instantiated.

## Structure
- Shared package ped_pkg: state enum (DONT_WALK, WALK, FLASH) and the default duration constants.
- One sub-module, ped_axis_fsm: per-axis request latch, edge detect, FSM, counters and blink logic. It is instantiated twice.
- The top level holds only the conflict checker and the wiring.

## Test plan
All scenarios use WALK_CYCLES=4, FLASH_CYCLES=4, BLINK_HALF=1.
- No request, full NS green phase → ns_walk stays 0 and ns_dont_walk stays 1 throughout.
- ns_btn pulse during NS red, then ns_green rises → ns_req clears and ns_walk=1 for 4 cycles, followed by ns_dont_walk pattern 1,0,1,0, then steady 1.
- ns_btn on the same cycle as the ns_green rise → WALK is granted on that edge.
- NS green lasts 2 cycles then yellow → ns_walk lasts 2 cycles, then FLASH for a full 4 cycles. If red arrives at flash cycle 2, ns_dont_walk=1 steady from the next edge.
- ew_btn pressed during EW WALK → ew_req stays 0. Pressed during FLASH → ew_req=1, and walk is granted at the next EW green.
- Async rst asserted mid-WALK → ns_walk=0, ns_dont_walk=1 and ns_req=0 immediately. With PED_CONFLICT_CHECK_EN defined, forcing ns_green=ew_green=1 gives fault=1 sticky and both walks 0.
